// File: rtl/regfile_wr_arbiter.sv
// Regfile write-port arbiter: WB passes through combinationally, MDU results queue in a 2-entry FIFO.
// MDU results write one cycle after acceptance at earliest; mdu_ready_o drops when full, wb_stall_o while draining.
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_rd_wr_en_i,
    input  logic [4:0]  wb_rd_idx_i,
    input  logic [63:0] wb_rd_data_i,
    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [4:0]  mdu_rd_idx_i,
    input  logic [63:0] mdu_rd_data_i,
    input  logic        mdu_issue_i,
    input  logic [4:0]  mdu_issue_rd_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_idx_o,
    output logic [63:0] rf_wr_data_o,
    output logic        wb_stall_o,
    output logic [31:0] busy_rd_o,
    output logic        issue_hazard_o,
    output logic        wb_waw_o
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic {WB_PRI, MDU_PRI} state_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } mdu_ent_t;

    state_t         r_state;
    mdu_ent_t       r_fifo [2];
    logic           r_wr_ptr;
    logic           r_rd_ptr;
    logic [1:0]     r_count;
    logic [CW-1:0]  r_starve;
    logic [31:0]    r_busy;

    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_wb_grant;
    logic [1:0]     w_count_nxt;
    mdu_ent_t       w_head;
    logic [31:0]    w_set;
    logic [31:0]    w_clr;
    logic [31:0]    w_busy_nxt;

    always_comb begin
        w_empty     = (r_count == 2'd0);
        w_full      = (r_count == 2'd2);
        mdu_ready_o = !rst_i && !w_full;
        w_push      = mdu_valid_i && mdu_ready_o;
        w_wb_grant  = !rst_i && (r_state == WB_PRI) && wb_rd_wr_en_i;
        // In MDU_PRI the WB request is ignored and the head drains every cycle.
        w_pop       = !rst_i && !w_empty && ((r_state == MDU_PRI) || !wb_rd_wr_en_i);
        w_head      = r_fifo[r_rd_ptr];
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

        rf_wr_en_o   = w_wb_grant || (w_pop && (w_head.idx != 5'd0));
        rf_wr_idx_o  = w_wb_grant ? wb_rd_idx_i  : w_head.idx;
        rf_wr_data_o = w_wb_grant ? wb_rd_data_i : w_head.data;

        w_set = '0;
        w_clr = '0;
        if (mdu_issue_i && (mdu_issue_rd_i != 5'd0))
            w_set[mdu_issue_rd_i] = 1'b1;
        if (w_pop && (w_head.idx != 5'd0))
            w_clr[w_head.idx] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;

        wb_stall_o     = !rst_i && (r_state == MDU_PRI);
        busy_rd_o      = rst_i ? 32'd0 : r_busy;
        issue_hazard_o = !rst_i && mdu_issue_i && (mdu_issue_rd_i != 5'd0) && r_busy[mdu_issue_rd_i];
        wb_waw_o       = w_wb_grant && (wb_rd_idx_i != 5'd0) && r_busy[wb_rd_idx_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= WB_PRI;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= '0;
            r_busy   <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{idx: mdu_rd_idx_i, data: mdu_rd_data_i};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;

            if (w_empty || w_pop)
                r_starve <= '0;
            else if (r_starve != CW'(STARVE_LIMIT))
                r_starve <= r_starve + CW'(1);

            case (r_state)
                WB_PRI:
                    if (!w_empty && ((r_starve == CW'(STARVE_LIMIT)) || (w_full && mdu_valid_i)))
                        r_state <= MDU_PRI;
                MDU_PRI:
                    if (w_count_nxt == 2'd0)
                        r_state <= WB_PRI;
                default:
                    r_state <= WB_PRI;
            endcase
        end
    end
endmodule
